// File: rtl/data_sram_responder.sv
// Data SRAM responder: a word-addressed 32-bit array behind a pipelined
// request/response CPU port. Accepted requests wait in an in-order queue and
// each one gets a single data_ok pulse LATENCY cycles after acceptance.
//
// Handshake: a request transfers on a rising edge where req && addr_ok.
// addr_ok never depends on req. data_ok has no ready; the CPU must take
// the response (rdata, err) in the cycle data_ok is high.
module data_sram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int CD_W  = 2;
  localparam int WORDS = 1 << ADDR_WIDTH;

  // Storage array; deliberately never reset so stores survive a reset.
  logic [31:0] mem_q [WORDS];

  // Response queue entries.
  logic            q_load_q [DEPTH];
  logic            q_err_q  [DEPTH];
  logic [31:0]     q_data_q [DEPTH];
  logic [CD_W-1:0] q_cd_q   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  req_err;
  logic                  accept;
  logic [31:0]           load_data;
  logic                  unused_addr_hi;

  // Upper address bits are ignored so the array aliases modulo its size.
  assign word_idx       = addr[ADDR_WIDTH+1:2];
  assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

  // Misaligned halfword/word accesses and the reserved size are errors.
  assign req_err = (size == 2'd3) ||
                   ((size == 2'd1) && addr[0]) ||
                   ((size == 2'd2) && (addr[1:0] != 2'b00));

  assign addr_ok = !reset && (count_q < CNT_W'(DEPTH));
  assign accept  = req && addr_ok;

  // Loads capture the word at acceptance; earlier stores are already in mem_q.
  assign load_data = (wr || req_err) ? 32'h0 : mem_q[word_idx];

  // The head is due once its countdown has run out.
  assign data_ok = !reset && (count_q != '0) && (q_cd_q[rd_ptr_q] == '0);
  assign rdata   = (data_ok && q_load_q[rd_ptr_q]) ? q_data_q[rd_ptr_q] : 32'h0;
  assign err     = data_ok && q_err_q[rd_ptr_q];

  // Pointer and occupancy next-state: push on accept, pop on data_ok.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (data_ok) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({accept, data_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset silently drops pending responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue entries: load a new entry on accept, otherwise count every entry down.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && (wr_ptr_q == PTR_W'(i))) begin
        q_load_q[i] <= !wr;
        q_err_q[i]  <= req_err;
        q_data_q[i] <= load_data;
        q_cd_q[i]   <= CD_W'(LATENCY - 1);
      end else if (q_cd_q[i] != '0) begin
        q_cd_q[i] <= q_cd_q[i] - CD_W'(1);
      end
    end
  end

  // Legal stores commit their enabled byte lanes at the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && wr && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
